ahb_arbiter_2m: RTL and testbench

AHB_ARBITER_2M -- requirements
Module: ahb_arbiter_2m

---
 rtl/ahb_arbiter_2m_if.sv | 23 ++
 rtl/ahb_arbiter_2m.sv | 103 ++++++++++
 tb/tb_ahb_arbiter_2m.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_2m_if.sv
// Bus-side signals of the two-master AHB arbiter, bundled so the arbiter and
// the bus fabric (or a bench) share one definition.
interface ahb_arbiter_2m_if;
    logic [1:0] HBUSREQ;
    logic [1:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [1:0] HGRANT;
    logic       HMASTER;
    logic       HMASTER_D;
    logic       HMASTLOCK;

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        input  HGRANT, HMASTER, HMASTER_D, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        output HGRANT, HMASTER, HMASTER_D, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter_2m.sv
// Two-master AHB arbiter: round-robin grant that is frozen during fixed-length
// bursts and locked sequences, plus address/data-phase owner tracking.
module ahb_arbiter_2m #(
    parameter bit DEFAULT_MASTER = 1'b0
) (
    input logic             HCLK,
    input logic             HRESET,
    ahb_arbiter_2m_if.slave bus
);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } trans_t;

    logic [1:0] r_grant;
    logic       r_master;
    logic       r_master_d;
    logic       r_mastlock;
    logic       r_last_grant;
    logic [3:0] r_beat_cnt;

    logic       w_grant_idx;
    logic       w_arb_ok;
    logic       w_any_req;
    logic       w_next_idx;
    logic [3:0] w_burst_beats;
    logic [3:0] w_next_beat;
    trans_t     w_trans;

    assign w_trans     = trans_t'(bus.HTRANS);
    assign w_grant_idx = r_grant[1];
    assign w_any_req   = |bus.HBUSREQ;
    // Re-arbitration is blocked while the owner has beats left or holds a lock.
    assign w_arb_ok    = (r_beat_cnt == 4'd0) &&
                         !(bus.HLOCK[r_master] && bus.HBUSREQ[r_master]);

    always_comb begin
        w_burst_beats = 4'd0;
        case (bus.HBURST)
            3'b010, 3'b011: w_burst_beats = 4'd3;
            3'b100, 3'b101: w_burst_beats = 4'd7;
            3'b110, 3'b111: w_burst_beats = 4'd15;
            default:        w_burst_beats = 4'd0;
        endcase
    end

    always_comb begin
        w_next_idx = DEFAULT_MASTER;
        case (bus.HBUSREQ)
            2'b01:   w_next_idx = 1'b0;
            2'b10:   w_next_idx = 1'b1;
            2'b11:   w_next_idx = ~r_last_grant;
            default: w_next_idx = DEFAULT_MASTER;
        endcase
    end

    always_comb begin
        w_next_beat = r_beat_cnt;
        if (bus.HREADY) begin
            case (w_trans)
                TR_IDLE:   w_next_beat = 4'd0;
                TR_BUSY:   w_next_beat = r_beat_cnt;
                TR_NONSEQ: w_next_beat = w_burst_beats;
                TR_SEQ:    w_next_beat = (r_beat_cnt != 4'd0) ? r_beat_cnt - 4'd1 : 4'd0;
                default:   w_next_beat = r_beat_cnt;
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_grant      <= DEFAULT_MASTER ? 2'b10 : 2'b01;
            r_master     <= DEFAULT_MASTER;
            r_master_d   <= DEFAULT_MASTER;
            r_mastlock   <= 1'b0;
            r_last_grant <= DEFAULT_MASTER;
            r_beat_cnt   <= 4'd0;
        end else begin
            r_beat_cnt <= w_next_beat;
            // Parking on the default master must not disturb round-robin history.
            if (w_arb_ok) begin
                r_grant <= w_next_idx ? 2'b10 : 2'b01;
                if (w_any_req) begin
                    r_last_grant <= w_next_idx;
                end
            end
            if (bus.HREADY) begin
                r_master   <= w_grant_idx;
                r_master_d <= r_master;
                r_mastlock <= bus.HLOCK[w_grant_idx];
            end
        end
    end

    assign bus.HGRANT    = r_grant;
    assign bus.HMASTER   = r_master;
    assign bus.HMASTER_D = r_master_d;
    assign bus.HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// Bench for ahb_arbiter_2m: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_ahb_arbiter_2m;

    localparam int DEF = 0;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101, INCR16 = 3'b111;

    logic HCLK;
    logic HRESET;
    int   total = 0;
    int   bad = 0;
    bit   checkEn = 0;

    ahb_arbiter_2m_if bus();

    ahb_arbiter_2m #(.DEFAULT_MASTER(1'b0)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Behavioural model: owner indices and a remaining-beat count as plain integers.
    int   burstLen [8] = '{1, 1, 4, 4, 8, 8, 16, 16};
    int   mOwner = DEF, mAddr = DEF, mData = DEF, mLast = DEF, mBeats = 0, mLock = 0;
    int   nReq, oldOwner;
    bit   mArbOk;

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            mOwner = DEF; mAddr = DEF; mData = DEF; mLast = DEF; mBeats = 0; mLock = 0;
        end else begin
            nReq     = int'(bus.HBUSREQ[0]) + int'(bus.HBUSREQ[1]);
            mArbOk   = (mBeats == 0) && !(bus.HLOCK[mAddr] && bus.HBUSREQ[mAddr]);
            oldOwner = mOwner;
            if (bus.HREADY) begin
                if (bus.HTRANS == IDLE) mBeats = 0;
                else if (bus.HTRANS == NONSEQ) mBeats = burstLen[bus.HBURST] - 1;
                else if (bus.HTRANS == SEQ && mBeats > 0) mBeats = mBeats - 1;
            end
            if (mArbOk) begin
                if (nReq == 0) mOwner = DEF;
                else if (nReq == 1) mOwner = bus.HBUSREQ[1] ? 1 : 0;
                else mOwner = 1 - mLast;
                if (nReq > 0) mLast = mOwner;
            end
            if (bus.HREADY) begin
                mData = mAddr;
                mAddr = oldOwner;
                mLock = int'(bus.HLOCK[oldOwner]);
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (checkEn) begin
            checkOutput("model HGRANT", int'(bus.HGRANT), (mOwner == 1) ? 2 : 1);
            checkOutput("model HMASTER", int'(bus.HMASTER), mAddr);
            checkOutput("model HMASTER_D", int'(bus.HMASTER_D), mData);
            checkOutput("model HMASTLOCK", int'(bus.HMASTLOCK), mLock);
            checkOutput("HGRANT onehot", $countones(bus.HGRANT), 1);
        end
    end

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] lock,
                                 input logic [1:0] trans, input logic [2:0] burst,
                                 input logic rdy);
        bus.HBUSREQ = req;
        bus.HLOCK   = lock;
        bus.HTRANS  = trans;
        bus.HBURST  = burst;
        bus.HREADY  = rdy;
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic step(input string name, input logic [1:0] req, input logic [1:0] lock,
                        input logic [1:0] trans, input logic [2:0] burst, input logic rdy,
                        input int expGrant, input int expMaster);
        applyStimulus(req, lock, trans, burst, rdy);
        checkOutput({name, " grant"}, int'(bus.HGRANT), expGrant);
        checkOutput({name, " master"}, int'(bus.HMASTER), expMaster);
    endtask

    // Reset is raised between edges; outputs must settle without a clock.
    task automatic resetDut();
        #2;
        HRESET = 1'b1;
        #1;
        checkOutput("reset HGRANT", int'(bus.HGRANT), 1);
        checkOutput("reset HMASTER", int'(bus.HMASTER), 0);
        checkOutput("reset HMASTER_D", int'(bus.HMASTER_D), 0);
        checkOutput("reset HMASTLOCK", int'(bus.HMASTLOCK), 0);
        @(posedge HCLK);
        @(negedge HCLK);
        HRESET  = 1'b0;
        checkEn = 1'b1;
    endtask

    initial begin
        int expG [4] = '{2, 1, 2, 1};
        int expM [4] = '{0, 1, 0, 1};
        int expD [4] = '{0, 0, 1, 0};
        HRESET = 1'b0;
        bus.HBUSREQ = 2'b00; bus.HLOCK = 2'b00; bus.HTRANS = IDLE;
        bus.HBURST = SINGLE; bus.HREADY = 1'b1;
        resetDut();

        // Reset mid locked INCR8 owned by master 1
        step("a1", 2'b10, 2'b00, IDLE, SINGLE, 1'b1, 2, 0);
        step("a2", 2'b10, 2'b00, IDLE, SINGLE, 1'b1, 2, 1);
        step("a3", 2'b10, 2'b10, NONSEQ, INCR8, 1'b1, 2, 1);
        checkOutput("a3 lock", int'(bus.HMASTLOCK), 1);
        step("a4", 2'b10, 2'b10, SEQ, INCR8, 1'b1, 2, 1);
        resetDut();
        step("a5", 2'b00, 2'b00, IDLE, SINGLE, 1'b1, 1, 0);
        step("a6", 2'b00, 2'b00, IDLE, SINGLE, 1'b1, 1, 0);

        // Round-robin alternation with both masters requesting
        resetDut();
        for (int k = 0; k < 4; k++) begin
            step("b", 2'b11, 2'b00, NONSEQ, SINGLE, 1'b1, expG[k], expM[k]);
            checkOutput("b master_d", int'(bus.HMASTER_D), expD[k]);
        end

        // INCR4 with an inserted BUSY holds the grant until the last beat
        resetDut();
        step("c1", 2'b10, 2'b00, IDLE, SINGLE, 1'b1, 2, 0);
        step("c2", 2'b00, 2'b00, IDLE, SINGLE, 1'b1, 1, 1);
        step("c3", 2'b00, 2'b00, IDLE, SINGLE, 1'b1, 1, 0);
        step("c4", 2'b11, 2'b00, NONSEQ, INCR4, 1'b1, 1, 0);
        step("c5", 2'b11, 2'b00, SEQ, INCR4, 1'b1, 1, 0);
        step("c6", 2'b11, 2'b00, BUSY, INCR4, 1'b1, 1, 0);
        step("c7", 2'b11, 2'b00, SEQ, INCR4, 1'b1, 1, 0);
        step("c8", 2'b11, 2'b00, SEQ, INCR4, 1'b1, 1, 0);
        step("c9", 2'b11, 2'b00, IDLE, SINGLE, 1'b1, 2, 0);

        // Grant change during wait states
        resetDut();
        for (int k = 0; k < 3; k++) step("d wait", 2'b10, 2'b00, IDLE, SINGLE, 1'b0, 2, 0);
        step("d4", 2'b10, 2'b00, IDLE, SINGLE, 1'b1, 2, 1);
        checkOutput("d4 master_d", int'(bus.HMASTER_D), 0);
        step("d5", 2'b10, 2'b00, IDLE, SINGLE, 1'b1, 2, 1);
        checkOutput("d5 master_d", int'(bus.HMASTER_D), 1);

        // Locked ownership by master 1, then lock release
        step("e1", 2'b11, 2'b10, IDLE, SINGLE, 1'b1, 2, 1);
        checkOutput("e1 lock", int'(bus.HMASTLOCK), 1);
        step("e2", 2'b11, 2'b10, IDLE, SINGLE, 1'b1, 2, 1);
        checkOutput("e2 lock", int'(bus.HMASTLOCK), 1);
        step("e3", 2'b11, 2'b00, IDLE, SINGLE, 1'b1, 1, 1);
        step("e4", 2'b11, 2'b00, IDLE, SINGLE, 1'b1, 2, 0);
        checkOutput("e4 lock", int'(bus.HMASTLOCK), 0);

        // INCR16 with owner dropping request mid-burst, terminated by IDLE
        resetDut();
        step("f1", 2'b01, 2'b00, NONSEQ, INCR16, 1'b1, 1, 0);
        step("f2", 2'b01, 2'b00, SEQ, INCR16, 1'b1, 1, 0);
        step("f3", 2'b01, 2'b00, SEQ, INCR16, 1'b1, 1, 0);
        step("f4", 2'b10, 2'b00, SEQ, INCR16, 1'b1, 1, 0);
        step("f5", 2'b10, 2'b00, SEQ, INCR16, 1'b1, 1, 0);
        step("f6", 2'b10, 2'b00, IDLE, SINGLE, 1'b1, 1, 0);
        step("f7", 2'b10, 2'b00, IDLE, SINGLE, 1'b1, 2, 0);

        // Randomized traffic, checked by the per-cycle model compare
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                resetDut();
            end else begin
                applyStimulus(2'($urandom_range(0, 3)),
                              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
                              2'($urandom_range(0, 3)),
                              3'($urandom_range(0, 7)),
                              ($urandom_range(0, 3) != 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
